swc_pck_transfer_output: RTL and testbench

Per-output-port consumer of the page-transfer requests produced by the swc_pck_transfer_input instances, one instance per input port. It arbitrates round-robin among the input ports that are offering a page to this output port. It acknowledges the winner, which is the read_mask bit fed back to that input, and queues page address and priority in a small FIFO. It then presents the queued entries to the output block through a valid/ack handshake.

---
 rtl/swc_pck_transfer_output.sv | 84 ++++++++
 tb/tb_swc_pck_transfer_output.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/swc_pck_transfer_output.sv
// swc_pck_transfer_output: round-robin arbiter over input-port page offers feeding a small transfer FIFO.
module swc_pck_transfer_output #(
  parameter int g_num_ports = 11,
  parameter int g_page_addr_width = 10,
  parameter int g_prio_width = 3,
  parameter int g_fifo_depth = 4
) (
  input  logic                                      clk_i,
  input  logic                                      rst_n_i,
  input  logic [g_num_ports-1:0]                    pti_transfer_valid_i,
  input  logic [g_num_ports*g_page_addr_width-1:0]  pti_pageaddr_i,
  input  logic [g_num_ports*g_prio_width-1:0]       pti_prio_i,
  output logic [g_num_ports-1:0]                    pti_transfer_ack_o,
  output logic                                      ob_transfer_valid_o,
  output logic [g_page_addr_width-1:0]              ob_pageaddr_o,
  output logic [g_prio_width-1:0]                   ob_prio_o,
  input  logic                                      ob_transfer_ack_i
);
  localparam int IW = (g_num_ports > 1) ? $clog2(g_num_ports) : 1;
  localparam int AW = $clog2(g_fifo_depth);
  localparam int CW = AW + 1;
  logic [IW-1:0] rr_ptr, gnt_idx, idx;
  logic found, push, pop;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [g_num_ports-1:0] eligible, ack_nxt;
  logic [g_page_addr_width-1:0] sel_page;
  logic [g_prio_width-1:0] sel_prio;
  logic [g_page_addr_width-1:0] page_mem [g_fifo_depth];
  logic [g_prio_width-1:0] prio_mem [g_fifo_depth];
  // A port whose ack is still high keeps its valid up for one more cycle; masking it avoids a double grant.
  assign eligible = pti_transfer_valid_i & ~pti_transfer_ack_o;
  always_comb begin
    gnt_idx = '0;
    idx = '0;
    found = 1'b0;
    for (int k = 1; k <= g_num_ports; k++) begin
      idx = IW'((int'(rr_ptr) + k) % g_num_ports);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        gnt_idx = idx;
      end
    end
  end
  always_comb begin
    sel_page = '0;
    sel_prio = '0;
    ack_nxt = '0;
    for (int i = 0; i < g_num_ports; i++) begin
      if (gnt_idx == IW'(i)) begin
        sel_page = pti_pageaddr_i[i*g_page_addr_width +: g_page_addr_width];
        sel_prio = pti_prio_i[i*g_prio_width +: g_prio_width];
      end
    end
    if (push) ack_nxt[gnt_idx] = 1'b1;
  end
  // Fullness is judged on the current count, so a pop on the same edge never frees a slot early.
  assign push = found && (count < CW'(g_fifo_depth));
  assign pop = ob_transfer_valid_o && ob_transfer_ack_i;
  assign ob_transfer_valid_o = count != '0;
  assign ob_pageaddr_o = ob_transfer_valid_o ? page_mem[rd_ptr] : '0;
  assign ob_prio_o = ob_transfer_valid_o ? prio_mem[rd_ptr] : '0;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pti_transfer_ack_o <= '0;
      rr_ptr <= IW'(g_num_ports - 1);
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      pti_transfer_ack_o <= ack_nxt;
      if (push) rr_ptr <= gnt_idx;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) begin
      page_mem[wr_ptr] <= sel_page;
      prio_mem[wr_ptr] <= sel_prio;
    end
  end
endmodule

// File: tb/tb_swc_pck_transfer_output.sv
// tb_swc_pck_transfer_output: directed vector table plus hand sequences for grant, full, wrap and reset cases.
module tb_swc_pck_transfer_output;
  localparam int N = 11;
  localparam int W = 10;
  localparam int P = 3;
  logic clk_i = 1'b0;
  logic rst_n_i = 1'b0;
  logic [N-1:0] valid = '0;
  logic [N*W-1:0] pa;
  logic [N*P-1:0] pp;
  logic [N-1:0] ack;
  logic ov;
  logic [W-1:0] opg;
  logic [P-1:0] opr;
  logic oba = 1'b0;
  logic [W-1:0] pg [N];
  logic [P-1:0] pr [N];
  int passed = 0;
  int total = 0;
  typedef struct packed {
    logic [N-1:0] v;
    logic oba;
    logic [N-1:0] ack;
    logic ov;
    logic [W-1:0] pg;
    logic [P-1:0] pr;
  } vec_t;
  vec_t tbl [20];
  swc_pck_transfer_output dut (
    .clk_i(clk_i),
    .rst_n_i(rst_n_i),
    .pti_transfer_valid_i(valid),
    .pti_pageaddr_i(pa),
    .pti_prio_i(pp),
    .pti_transfer_ack_o(ack),
    .ob_transfer_valid_o(ov),
    .ob_pageaddr_o(opg),
    .ob_prio_o(opr),
    .ob_transfer_ack_i(oba)
  );
  always #5 clk_i = ~clk_i;
  always_comb begin
    pa = '0;
    pp = '0;
    for (int i = 0; i < N; i++) begin
      pa[i*W +: W] = pg[i];
      pp[i*P +: P] = pr[i];
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic chk_out(input string nm, input logic [N-1:0] a, input logic v, input logic [W-1:0] p, input logic [P-1:0] q);
    chk({nm, ".ack"}, 32'(ack), 32'(a));
    chk({nm, ".valid"}, 32'(ov), 32'(v));
    chk({nm, ".page"}, 32'(opg), 32'(p));
    chk({nm, ".prio"}, 32'(opr), 32'(q));
  endtask
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask
  task automatic do_reset;
    rst_n_i = 1'b0;
    valid = '0;
    oba = 1'b0;
    tick();
    tick();
    rst_n_i = 1'b1;
  endtask
  initial begin
    for (int i = 0; i < N; i++) begin
      pg[i] = '0;
      pr[i] = '0;
    end
    tick();
    tick();
    chk_out("reset", '0, 1'b0, '0, '0);
    rst_n_i = 1'b1;
    pg[3] = 10'd123;
    pr[3] = 3'd2;
    valid = 11'h008;
    tick();
    chk_out("single_grant", 11'h008, 1'b1, 10'd123, 3'd2);
    tick();
    chk_out("single_hold", 11'h000, 1'b1, 10'd123, 3'd2);
    valid = '0;
    oba = 1'b1;
    tick();
    chk_out("single_pop", 11'h000, 1'b0, '0, '0);
    do_reset();
    pg[0] = 10'd10; pr[0] = 3'd1;
    pg[2] = 10'd20; pr[2] = 3'd2;
    pg[5] = 10'd50; pr[5] = 3'd5;
    valid = 11'h025;
    tick();
    chk_out("rr_port0", 11'h001, 1'b1, 10'd10, 3'd1);
    tick();
    chk_out("rr_port2", 11'h004, 1'b1, 10'd10, 3'd1);
    valid = 11'h024;
    tick();
    chk_out("rr_port5", 11'h020, 1'b1, 10'd10, 3'd1);
    valid = 11'h020;
    tick();
    chk_out("rr_idle", 11'h000, 1'b1, 10'd10, 3'd1);
    valid = '0;
    oba = 1'b1;
    tick();
    chk_out("rr_pop1", 11'h000, 1'b1, 10'd20, 3'd2);
    tick();
    chk_out("rr_pop2", 11'h000, 1'b1, 10'd50, 3'd5);
    tick();
    chk_out("rr_pop3", 11'h000, 1'b0, '0, '0);
    do_reset();
    for (int i = 0; i < N; i++) begin
      pg[i] = W'(100 + i);
      pr[i] = P'(i);
    end
    tbl[0]  = {11'h25a, 1'b0, 11'h002, 1'b1, 10'd101, 3'd1};
    tbl[1]  = {11'h25a, 1'b0, 11'h008, 1'b1, 10'd101, 3'd1};
    tbl[2]  = {11'h258, 1'b0, 11'h010, 1'b1, 10'd101, 3'd1};
    tbl[3]  = {11'h250, 1'b0, 11'h040, 1'b1, 10'd101, 3'd1};
    tbl[4]  = {11'h240, 1'b0, 11'h000, 1'b1, 10'd101, 3'd1};
    tbl[5]  = {11'h200, 1'b0, 11'h000, 1'b1, 10'd101, 3'd1};
    tbl[6]  = {11'h200, 1'b1, 11'h000, 1'b1, 10'd103, 3'd3};
    tbl[7]  = {11'h200, 1'b0, 11'h200, 1'b1, 10'd103, 3'd3};
    tbl[8]  = {11'h200, 1'b1, 11'h000, 1'b1, 10'd104, 3'd4};
    tbl[9]  = {11'h000, 1'b1, 11'h000, 1'b1, 10'd106, 3'd6};
    tbl[10] = {11'h004, 1'b1, 11'h004, 1'b1, 10'd109, 3'd1};
    tbl[11] = {11'h004, 1'b1, 11'h000, 1'b1, 10'd102, 3'd2};
    tbl[12] = {11'h000, 1'b1, 11'h000, 1'b0, 10'd0, 3'd0};
    tbl[13] = {11'h000, 1'b1, 11'h000, 1'b0, 10'd0, 3'd0};
    tbl[14] = {11'h020, 1'b0, 11'h020, 1'b1, 10'd105, 3'd5};
    tbl[15] = {11'h0a2, 1'b0, 11'h080, 1'b1, 10'd105, 3'd5};
    tbl[16] = {11'h082, 1'b0, 11'h002, 1'b1, 10'd105, 3'd5};
    tbl[17] = {11'h002, 1'b1, 11'h000, 1'b1, 10'd107, 3'd7};
    tbl[18] = {11'h000, 1'b1, 11'h000, 1'b1, 10'd101, 3'd1};
    tbl[19] = {11'h000, 1'b1, 11'h000, 1'b0, 10'd0, 3'd0};
    for (int k = 0; k < 20; k++) begin
      valid = tbl[k].v;
      oba = tbl[k].oba;
      tick();
      chk_out($sformatf("vec%0d", k), tbl[k].ack, tbl[k].ov, tbl[k].pg, tbl[k].pr);
    end
    do_reset();
    valid = 11'h112;
    tick();
    chk_out("mid_fill1", 11'h002, 1'b1, 10'd101, 3'd1);
    tick();
    chk_out("mid_fill2", 11'h010, 1'b1, 10'd101, 3'd1);
    valid = 11'h110;
    tick();
    chk_out("mid_fill3", 11'h100, 1'b1, 10'd101, 3'd1);
    rst_n_i = 1'b0;
    #1;
    chk_out("mid_async_reset", 11'h000, 1'b0, '0, '0);
    valid = '0;
    tick();
    chk_out("mid_held_reset", 11'h000, 1'b0, '0, '0);
    rst_n_i = 1'b1;
    valid = 11'h101;
    tick();
    chk_out("post_reset", 11'h001, 1'b1, 10'd100, 3'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
